// File: rtl/disp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : disp_arbiter
// Brief    : Round-robin owner arbitration for a shared BCD display, with a
//            minimum hold time, a maximum slice under contention and one dead
//            cycle between owners.
// Revision : 1.0
// ============================================================================
module disp_arbiter #(
    parameter int HOLD_CYC  = 50_000_000,
    parameter int SLICE_CYC = 150_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    input  logic [23:0] data2,
    output logic [2:0]  grant,
    output logic [1:0]  cur_id,
    output logic [23:0] bcd_data,
    output logic        disp_en
);

    localparam logic [31:0] C_HOLD_LAST  = 32'(HOLD_CYC - 1);
    localparam logic [31:0] C_SLICE_LAST = 32'(SLICE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t      state_q,   state_d;
    logic [2:0]  grant_q,   grant_d;
    logic [1:0]  cur_id_q,  cur_id_d;
    logic [23:0] bcd_q,     bcd_d;
    logic        en_q,      en_d;
    logic [31:0] cnt_q,     cnt_d;
    logic [1:0]  last_id_q, last_id_d;

    logic        w_arb_valid;
    logic [1:0]  w_arb_id;
    logic [23:0] w_arb_data;
    logic [23:0] w_own_data;
    logic        w_own_req;
    logic        w_other_req;
    logic        w_release;

    // Search starts one past the previous owner so a held request rotates.
    always_comb begin
        w_arb_valid = |req;
        w_arb_id    = 2'd0;
        case (last_id_q)
            2'd0: begin
                if (req[1])      w_arb_id = 2'd1;
                else if (req[2]) w_arb_id = 2'd2;
                else             w_arb_id = 2'd0;
            end
            2'd1: begin
                if (req[2])      w_arb_id = 2'd2;
                else if (req[0]) w_arb_id = 2'd0;
                else             w_arb_id = 2'd1;
            end
            default: begin
                if (req[0])      w_arb_id = 2'd0;
                else if (req[1]) w_arb_id = 2'd1;
                else             w_arb_id = 2'd2;
            end
        endcase
    end

    always_comb begin
        w_arb_data = data0;
        case (w_arb_id)
            2'd1:    w_arb_data = data1;
            2'd2:    w_arb_data = data2;
            default: w_arb_data = data0;
        endcase
        w_own_data = data0;
        case (cur_id_q)
            2'd1:    w_own_data = data1;
            2'd2:    w_own_data = data2;
            default: w_own_data = data0;
        endcase
    end

    assign w_own_req   = |(req & grant_q);
    assign w_other_req = |(req & ~grant_q);
    assign w_release   = (!w_own_req && (cnt_q >= C_HOLD_LAST)) ||
                         ((cnt_q == C_SLICE_LAST) && w_other_req);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cur_id_d  = cur_id_q;
        bcd_d     = bcd_q;
        en_d      = en_q;
        cnt_d     = cnt_q;
        last_id_d = last_id_q;
        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
                bcd_d   = 24'd0;
                en_d    = 1'b0;
                if (w_arb_valid) begin
                    state_d  = ST_GRANT;
                    grant_d  = 3'(3'b001 << w_arb_id);
                    cur_id_d = w_arb_id;
                    bcd_d    = w_arb_data;
                    en_d     = 1'b1;
                    cnt_d    = 32'd0;
                end
            end
            ST_GRANT: begin
                bcd_d = w_own_data;
                en_d  = 1'b1;
                cnt_d = (cnt_q == C_SLICE_LAST) ? cnt_q : cnt_q + 32'd1;
                if (w_release) begin
                    // Recording the owner now makes the RELEASE-cycle search skip it.
                    state_d   = ST_RELEASE;
                    grant_d   = 3'b000;
                    bcd_d     = 24'd0;
                    en_d      = 1'b0;
                    last_id_d = cur_id_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
                bcd_d   = 24'd0;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= 3'b000;
            cur_id_q  <= 2'd0;
            bcd_q     <= 24'd0;
            en_q      <= 1'b0;
            cnt_q     <= 32'd0;
            last_id_q <= 2'd2;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cur_id_q  <= cur_id_d;
            bcd_q     <= bcd_d;
            en_q      <= en_d;
            cnt_q     <= cnt_d;
            last_id_q <= last_id_d;
        end
    end

    assign grant    = grant_q;
    assign cur_id   = cur_id_q;
    assign bcd_data = bcd_q;
    assign disp_en  = en_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_arbiter
// Brief    : Directed self-checking bench for disp_arbiter (HOLD=4, SLICE=10).
// Revision : 1.0
// ============================================================================
module tb_disp_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [23:0] data0, data1, data2;
    logic [2:0]  grant;
    logic [1:0]  cur_id;
    logic [23:0] bcd_data;
    logic        disp_en;

    int vectors;
    int miscompares;

    disp_arbiter #(
        .HOLD_CYC  (4),
        .SLICE_CYC (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data0    (data0),
        .data1    (data1),
        .data2    (data2),
        .grant    (grant),
        .cur_id   (cur_id),
        .bcd_data (bcd_data),
        .disp_en  (disp_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] eg, input logic [1:0] ec,
                         input logic ee, input logic [23:0] eb);
        vectors++;
        assert ({grant, cur_id, disp_en, bcd_data} === {eg, ec, ee, eb}) else begin
            miscompares++;
            $error("FAIL %s: observed grant=%b cur_id=%0d disp_en=%b bcd=%h, expected grant=%b cur_id=%0d disp_en=%b bcd=%h",
                   tag, grant, cur_id, disp_en, bcd_data, eg, ec, ee, eb);
        end
    endtask

    function automatic logic [23:0] dsel(input int id);
        if (id == 0) return data0;
        if (id == 1) return data1;
        return data2;
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        req   = 3'b111;
        data0 = 24'h123456;
        data1 = 24'h000001;
        data2 = 24'h654321;

        // Reset held two cycles with all requests high
        cyc(); check("rst_hold0", 3'b000, 2'd0, 1'b0, 24'h0);
        cyc(); check("rst_hold1", 3'b000, 2'd0, 1'b0, 24'h0);
        reset = 1'b0;

        // Full contention: 0,1,2,0 with 10-cycle slices and single dead cycles
        for (int o = 0; o < 4; o++) begin
            for (int k = 0; k < 10; k++) begin
                cyc();
                check($sformatf("cont_o%0d_k%0d", o, k), 3'(3'b001 << (o % 3)),
                      2'(o % 3), 1'b1, dsel(o % 3));
            end
            if (o == 3) req = 3'b000;
            cyc();
            check($sformatf("cont_rel%0d", o), 3'b000, 2'(o % 3), 1'b0, 24'h0);
        end
        cyc(); check("cont_idle", 3'b000, 2'd0, 1'b0, 24'h0);

        // Early drop: one-cycle request still holds for 4 cycles
        req = 3'b001;
        cyc(); check("drop_g0", 3'b001, 2'd0, 1'b1, 24'h123456);
        req = 3'b000;
        for (int k = 1; k < 4; k++) begin
            cyc(); check($sformatf("drop_g%0d", k), 3'b001, 2'd0, 1'b1, 24'h123456);
        end
        cyc(); check("drop_rel", 3'b000, 2'd0, 1'b0, 24'h0);
        cyc(); check("drop_idle", 3'b000, 2'd0, 1'b0, 24'h0);

        // Single requester held 100 cycles, with a live data change midway
        req = 3'b010;
        for (int i = 0; i < 100; i++) begin
            cyc();
            check($sformatf("single_%0d", i), 3'b010, 2'd1, 1'b1,
                  (i <= 50) ? 24'h000001 : 24'h000002);
            if (i == 50) data1 = 24'h000002;
        end

        // Preemption of a saturated owner, then reset while requester 2 owns
        req = 3'b100;
        cyc(); check("pre_rel", 3'b000, 2'd1, 1'b0, 24'h0);
        cyc(); check("pre_g2", 3'b100, 2'd2, 1'b1, 24'h654321);
        reset = 1'b1;
        req   = 3'b111;
        cyc(); check("mid_rst", 3'b000, 2'd0, 1'b0, 24'h0);
        reset = 1'b0;
        cyc(); check("post_rst", 3'b001, 2'd0, 1'b1, 24'h123456);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
